// File: rtl/regfile_alu_pipe_if.sv
// Command and result channels of the register-file/ALU pipe, plus the mirrored pad outputs.
// The slave modport is the datapath side; the master modport is the command source and result sink.
interface regfile_alu_pipe_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic              cmd_sat;
    logic [ADDR_W-1:0] cmd_rd;
    logic [ADDR_W-1:0] cmd_rs1;
    logic [ADDR_W-1:0] cmd_rs2;
    logic [WIDTH-1:0]  cmd_imm;
    logic              res_valid;
    logic              res_ready;
    logic [WIDTH-1:0]  res_data;
    logic              res_carry;
    logic [WIDTH-1:0]  io_out;
    logic [WIDTH-1:0]  io_oeb;

    modport slave (
        input  cmd_valid, cmd_op, cmd_sat, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, io_out, io_oeb
    );

    modport master (
        output cmd_valid, cmd_op, cmd_sat, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, io_out, io_oeb
    );
endinterface

// File: rtl/regfile_alu_pipe.sv
// Register file feeding a two-stage ALU pipe (execute E, output O) with carry chaining,
// unsigned saturation, E->operand forwarding and valid/ready back-pressure.
module regfile_alu_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    regfile_alu_pipe_if.slave bus
);
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_ADDC = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_LDI  = 3'b110,
        OP_RD   = 3'b111
    } op_e;

    logic [WIDTH-1:0]  rf_q [DEPTH];
    logic              carry_q, carry_d;
    logic              e_valid_q, e_valid_d;
    op_e               e_op_q;
    logic              e_sat_q;
    logic [ADDR_W-1:0] e_rd_q;
    logic [WIDTH-1:0]  e_a_q, e_b_q;
    logic              res_valid_q, res_valid_d;
    logic [WIDTH-1:0]  res_data_q;
    logic              res_carry_q;
    logic [WIDTH-1:0]  io_out_q, io_oeb_q;

    logic              e_retire, e_wr, accept, res_xfer;
    logic [WIDTH-1:0]  alu_res, op_a, op_b;
    logic [WIDTH:0]    sum, diff;

    assign e_retire      = e_valid_q & (~res_valid_q | bus.res_ready);
    assign e_wr          = e_retire && (e_op_q != OP_RD) && !(ZERO_REG && (e_rd_q == '0));
    assign bus.cmd_ready = ~e_valid_q | e_retire;
    assign accept        = bus.cmd_valid & bus.cmd_ready;
    assign res_xfer      = res_valid_q & bus.res_ready;
    assign e_valid_d     = accept | (e_valid_q & ~e_retire);
    assign res_valid_d   = e_retire | (res_valid_q & ~bus.res_ready);

    // Operand read: the op retiring this edge is not yet in rf_q, so bypass its result.
    always_comb begin
        op_a = rf_q[bus.cmd_rs1];
        op_b = rf_q[bus.cmd_rs2];
        if (ZERO_REG && (bus.cmd_rs1 == '0)) begin
            op_a = '0;
        end else if (e_wr && (bus.cmd_rs1 == e_rd_q)) begin
            op_a = alu_res;
        end
        if (ZERO_REG && (bus.cmd_rs2 == '0)) begin
            op_b = '0;
        end else if (e_wr && (bus.cmd_rs2 == e_rd_q)) begin
            op_b = alu_res;
        end
    end

    always_comb begin
        sum     = {1'b0, e_a_q} + {1'b0, e_b_q} + {{WIDTH{1'b0}}, (e_op_q == OP_ADDC) & carry_q};
        diff    = {1'b0, e_a_q} - {1'b0, e_b_q};
        alu_res = '0;
        carry_d = carry_q;
        case (e_op_q)
            OP_ADD, OP_ADDC: begin
                carry_d = sum[WIDTH];
                alu_res = (e_sat_q && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
            end
            OP_SUB: begin
                carry_d = diff[WIDTH];
                alu_res = (e_sat_q && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
            end
            OP_AND:  alu_res = e_a_q & e_b_q;
            OP_OR:   alu_res = e_a_q | e_b_q;
            OP_XOR:  alu_res = e_a_q ^ e_b_q;
            OP_LDI:  alu_res = e_b_q;
            OP_RD:   alu_res = e_a_q;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rf_q        <= '{default: '0};
            carry_q     <= 1'b0;
            e_valid_q   <= 1'b0;
            e_op_q      <= OP_ADD;
            e_sat_q     <= 1'b0;
            e_rd_q      <= '0;
            e_a_q       <= '0;
            e_b_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            io_out_q    <= '0;
            io_oeb_q    <= '1;
        end else begin
            e_valid_q   <= e_valid_d;
            res_valid_q <= res_valid_d;
            if (accept) begin
                e_op_q  <= op_e'(bus.cmd_op);
                e_sat_q <= bus.cmd_sat;
                e_rd_q  <= bus.cmd_rd;
                e_a_q   <= op_a;
                // LDI carries its immediate through the B operand slot.
                e_b_q   <= (op_e'(bus.cmd_op) == OP_LDI) ? bus.cmd_imm : op_b;
            end
            if (e_retire) begin
                res_data_q  <= alu_res;
                res_carry_q <= carry_d;
                carry_q     <= carry_d;
            end
            if (e_wr) begin
                rf_q[e_rd_q] <= alu_res;
            end
            if (res_xfer) begin
                io_out_q <= res_data_q;
                io_oeb_q <= '0;
            end
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_carry = res_carry_q;
    assign bus.io_out    = io_out_q;
    assign bus.io_oeb    = io_oeb_q;
endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Directed bench for regfile_alu_pipe (WIDTH=32, DEPTH=16): a vector table run one op at a
// time, plus hand sequences for forwarding, back-pressure and reset with the pipe full.
module tb_regfile_alu_pipe;
    typedef enum logic [2:0] {
        ADD = 3'b000, SUB = 3'b001, ADDC = 3'b010, AND_ = 3'b011,
        OR_ = 3'b100, XOR_ = 3'b101, LDI = 3'b110, RD = 3'b111
    } op_e;

    typedef struct {
        logic [2:0]  op;
        logic        sat;
        logic [3:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp_data;
        logic        exp_carry;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    regfile_alu_pipe_if #(.WIDTH(32), .ADDR_W(4)) bus ();

    regfile_alu_pipe #(.WIDTH(32), .DEPTH(16), .ZERO_REG(1'b1)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected one");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic sat, input logic [3:0] rd,
                                input logic [3:0] rs1, input logic [3:0] rs2,
                                input logic [31:0] imm, input logic [31:0] ed, input logic ec);
        vec_t v;
        v.op = op; v.sat = sat; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.exp_data = ed; v.exp_carry = ec;
        return v;
    endfunction

    task automatic set_cmd(input logic [2:0] op, input logic sat, input logic [3:0] rd,
                           input logic [3:0] rs1, input logic [3:0] rs2, input logic [31:0] imm);
        bus.cmd_op = op; bus.cmd_sat = sat; bus.cmd_rd = rd;
        bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_imm = imm;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [2:0] op, input logic sat, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] rs2, input logic [31:0] imm);
        set_cmd(op, sat, rd, rs1, rs2, imm);
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge clk);
        check("send_ready", {31'b0, bus.cmd_ready}, 32'd1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    // Expects res_ready held high; checks the result, then the pad mirror after the transfer.
    task automatic get_result(input string name, input logic [31:0] ed, input logic ec);
        for (int i = 0; i < 20 && !bus.res_valid; i++) @(negedge clk);
        check({name, "_valid"}, {31'b0, bus.res_valid}, 32'd1);
        check({name, "_data"}, bus.res_data, ed);
        check({name, "_carry"}, {31'b0, bus.res_carry}, {31'b0, ec});
        @(posedge clk);
        #1;
        check({name, "_io_out"}, bus.io_out, ed);
        check({name, "_io_oeb"}, bus.io_oeb, 32'h0);
        @(negedge clk);
    endtask

    vec_t        vecs[22];
    logic [31:0] bp_imm[3];
    logic [31:0] got[$];
    logic [31:0] g;
    int          k, n_acc;

    initial begin
        vecs[0]  = mk(LDI,  1'b0, 4'd1,  4'd0, 4'd0, 32'h5,        32'h5,        1'b0);
        vecs[1]  = mk(LDI,  1'b0, 4'd1,  4'd0, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        vecs[2]  = mk(LDI,  1'b0, 4'd2,  4'd0, 4'd0, 32'h1,        32'h1,        1'b0);
        vecs[3]  = mk(ADD,  1'b0, 4'd3,  4'd1, 4'd2, 32'h0,        32'h0,        1'b1);
        vecs[4]  = mk(ADDC, 1'b0, 4'd4,  4'd0, 4'd0, 32'h0,        32'h1,        1'b0);
        vecs[5]  = mk(RD,   1'b0, 4'd0,  4'd3, 4'd0, 32'h0,        32'h0,        1'b0);
        vecs[6]  = mk(LDI,  1'b0, 4'd5,  4'd0, 4'd0, 32'hFFFFFFF0, 32'hFFFFFFF0, 1'b0);
        vecs[7]  = mk(LDI,  1'b0, 4'd6,  4'd0, 4'd0, 32'h20,       32'h20,       1'b0);
        vecs[8]  = mk(ADD,  1'b1, 4'd7,  4'd5, 4'd6, 32'h0,        32'hFFFFFFFF, 1'b1);
        vecs[9]  = mk(RD,   1'b0, 4'd0,  4'd7, 4'd0, 32'h0,        32'hFFFFFFFF, 1'b1);
        vecs[10] = mk(LDI,  1'b0, 4'd8,  4'd0, 4'd0, 32'h3,        32'h3,        1'b1);
        vecs[11] = mk(LDI,  1'b0, 4'd9,  4'd0, 4'd0, 32'h5,        32'h5,        1'b1);
        vecs[12] = mk(SUB,  1'b1, 4'd10, 4'd8, 4'd9, 32'h0,        32'h0,        1'b1);
        vecs[13] = mk(SUB,  1'b0, 4'd11, 4'd9, 4'd8, 32'h0,        32'h2,        1'b0);
        vecs[14] = mk(SUB,  1'b0, 4'd12, 4'd8, 4'd9, 32'h0,        32'hFFFFFFFE, 1'b1);
        vecs[15] = mk(AND_, 1'b0, 4'd13, 4'd5, 4'd6, 32'h0,        32'h20,       1'b1);
        vecs[16] = mk(OR_,  1'b0, 4'd13, 4'd8, 4'd9, 32'h0,        32'h7,        1'b1);
        vecs[17] = mk(XOR_, 1'b0, 4'd14, 4'd8, 4'd9, 32'h0,        32'h6,        1'b1);
        vecs[18] = mk(LDI,  1'b0, 4'd0,  4'd0, 4'd0, 32'h9,        32'h9,        1'b1);
        vecs[19] = mk(RD,   1'b0, 4'd0,  4'd0, 4'd0, 32'h0,        32'h0,        1'b1);
        vecs[20] = mk(ADDC, 1'b0, 4'd15, 4'd8, 4'd9, 32'h0,        32'h9,        1'b0);
        vecs[21] = mk(ADD,  1'b0, 4'd15, 4'd1, 4'd1, 32'h0,        32'hFFFFFFFE, 1'b1);
        bp_imm[0] = 32'h11; bp_imm[1] = 32'h22; bp_imm[2] = 32'h33;

        // Reset held with a command offered.
        bus.res_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        set_cmd(LDI, 1'b0, 4'd1, 4'd0, 4'd0, 32'hDEAD);
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        check("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
        check("rst_res_data", bus.res_data, 32'h0);
        check("rst_io_out", bus.io_out, 32'h0);
        check("rst_io_oeb", bus.io_oeb, 32'hFFFFFFFF);
        bus.cmd_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: accept at edge N, result visible after edge N+1.
        set_cmd(LDI, 1'b0, 4'd1, 4'd0, 4'd0, 32'h5);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("lat_n_valid", {31'b0, bus.res_valid}, 32'd0);
        @(negedge clk);
        check("lat_n1_valid", {31'b0, bus.res_valid}, 32'd1);
        check("lat_n1_data", bus.res_data, 32'h5);
        check("lat_oeb_before", bus.io_oeb, 32'hFFFFFFFF);
        @(posedge clk);
        #1 check("lat_oeb_after", bus.io_oeb, 32'h0);
        @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            send(vecs[i].op, vecs[i].sat, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            get_result($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_carry);
        end

        // Back-to-back forwarding, one op per cycle.
        set_cmd(LDI, 1'b0, 4'd1, 4'd0, 4'd0, 32'd7);
        bus.cmd_valid = 1'b1;
        #1 check("fwd_rdy0", {31'b0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        set_cmd(ADD, 1'b0, 4'd2, 4'd1, 4'd1, 32'd0);
        #1 check("fwd_rdy1", {31'b0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        check("fwd_r1_valid", {31'b0, bus.res_valid}, 32'd1);
        check("fwd_r1", bus.res_data, 32'd7);
        set_cmd(ADD, 1'b0, 4'd3, 4'd2, 4'd1, 32'd0);
        #1 check("fwd_rdy2", {31'b0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        check("fwd_r2", bus.res_data, 32'd14);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("fwd_r3_valid", {31'b0, bus.res_valid}, 32'd1);
        check("fwd_r3", bus.res_data, 32'd21);
        @(negedge clk);
        send(RD, 1'b0, 4'd0, 4'd3, 4'd0, 32'd0);
        get_result("fwd_rd_r3", 32'd21, 1'b0);

        // Back-pressure: three commands offered over five stalled cycles.
        bus.res_ready = 1'b0;
        k = 0;
        n_acc = 0;
        for (int c = 0; c < 5; c++) begin
            bus.cmd_valid = (k < 3);
            if (k < 3) set_cmd(LDI, 1'b0, 4'(k + 1), 4'd0, 4'd0, bp_imm[k]);
            #1;
            if (bus.cmd_valid && bus.cmd_ready) begin k++; n_acc++; end
            if (c >= 2) check($sformatf("bp_frozen%0d", c), bus.res_data, 32'h11);
            @(negedge clk);
        end
        check("bp_accepted", n_acc, 32'd2);
        check("bp_ready_low", {31'b0, bus.cmd_ready}, 32'd0);
        bus.res_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus.cmd_valid = (k < 3);
            if (k < 3) set_cmd(LDI, 1'b0, 4'(k + 1), 4'd0, 4'd0, bp_imm[k]);
            #1;
            if (bus.cmd_valid && bus.cmd_ready) k++;
            if (bus.res_valid) got.push_back(bus.res_data);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        check("bp_count", got.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            g = (got.size() > i) ? got[i] : 32'hXXXXXXXX;
            check($sformatf("bp_order%0d", i), g, bp_imm[i]);
        end

        // Reset with O holding a result and E holding a second op.
        bus.res_ready = 1'b0;
        set_cmd(LDI, 1'b0, 4'd1, 4'd0, 4'd0, 32'h55);
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        set_cmd(LDI, 1'b0, 4'd2, 4'd0, 4'd0, 32'h66);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("mid_full_valid", {31'b0, bus.res_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_res_valid", {31'b0, bus.res_valid}, 32'd0);
        check("mid_res_data", bus.res_data, 32'h0);
        check("mid_io_oeb", bus.io_oeb, 32'hFFFFFFFF);
        check("mid_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        send(RD, 1'b0, 4'd0, 4'd1, 4'd0, 32'd0);
        get_result("mid_rd_r1", 32'h0, 1'b0);
        send(RD, 1'b0, 4'd0, 4'd2, 4'd0, 32'd0);
        get_result("mid_rd_r2", 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_alu_pipe.md
Name: regfile_alu_pipe

Overview:
- Next-generation user-area datapath: a parametrised register file plus a 2-stage ALU pipeline.
- Replaces the fixed-width adder/regfile datapath.
- Commands arrive on a valid/ready port driven from LA bits.
- Results leave on a valid/ready port and are mirrored to user IO pads.
- Adds carry chaining, saturation, result forwarding and back-pressure.

Parameters:
- WIDTH, 32, datapath and register width in bits (8..64).
- DEPTH, 16, number of registers (power of two, 4..64).
- ADDR_W, $clog2(DEPTH), register address width.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.

Ports:
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on a cycle where cmd_valid & cmd_ready.
- cmd_op  in  3  000 ADD, 001 SUB, 010 ADDC, 011 AND, 100 OR, 101 XOR, 110 LDI, 111 RD.
- cmd_sat  in  1  unsigned saturation for ADD/SUB/ADDC.
- cmd_rd  in  ADDR_W  destination register.
- cmd_rs1  in  ADDR_W  source register 1.
- cmd_rs2  in  ADDR_W  source register 2.
- cmd_imm  in  WIDTH  immediate for LDI.
- res_valid  out  1  result held in output register.
- res_ready  in  1  consumer takes the result.
- res_data  out  WIDTH  result value.
- res_carry  out  1  carry flag after this result.
- io_out  out  WIDTH  last result delivered.
- io_oeb  out  WIDTH  pad output enables, active low.

Behaviour:
- Reset (async assert, sync release): all registers 0, carry flag 0, E-stage valid 0, res_valid 0, res_data 0, res_carry 0, io_out 0, io_oeb all ones.
- Handshake: a transfer occurs when valid and ready are both high at a rising edge.
  - res_valid stays high and res_data/res_carry stay stable until res_ready is seen.
- Pipeline stage E (execute):
  - On accept, the opcode, rd and both operands are captured.
  - Operand read uses regfile contents, with forwarding: if an op in E writing rd is retiring on the same edge and rs matches that rd, the forwarded ALU value is used.
  - ZERO_REG=1 and rs=0 reads 0, and no forwarding is applied.
- Stage O (output):
  - E retires when !res_valid | res_ready.
  - On retire: the output register loads; regfile[rd] is written, except for RD and except rd=0 when ZERO_REG=1; the carry flag is updated.
- Ready: cmd_ready = !e_valid | e_retire. The pipe sustains 1 op/cycle when res_ready is held high.
- Latency: accept at edge N -> res_valid high after edge N+1.
- Arithmetic is on WIDTH+1 bits:
  - ADD: a+b. SUB: a-b. ADDC: a+b+carry_flag.
  - Carry flag = bit WIDTH (for SUB, borrow = 1 when a<b).
  - Flag updates only on ADD/SUB/ADDC.
  - cmd_sat=1: ADD/ADDC overflow -> all ones; SUB borrow -> 0. The flag still records the raw carry/borrow.
- Logic ops: bitwise on operands. LDI result = cmd_imm. RD result = rs1 value, with no register write.
- res_carry = carry flag value after the op.
- IO: on each result transfer, io_out <= res_data. io_oeb goes all zero after the first result transfer and stays zero until reset.
- Simultaneous events:
  - Result handshake on the same cycle as retire of the next op: the output register reloads and res_valid stays 1.
  - Command accept on the same cycle as E retire: E reloads.
- Reset mid-operation: in-flight E and O contents are discarded; no partial regfile write.

Test Plan:
- Reset: hold wb_rst_ni=0 with cmd_valid=1 -> cmd_ready=1, res_valid=0, io_oeb=all ones. Release, LDI r1=5 -> res_data=5 two edges after accept.
- Back-to-back forwarding: LDI r1=7, ADD r2=r1+r1, ADD r3=r2+r1 on consecutive cycles with res_ready=1 -> results 7, 14, 21 on consecutive cycles; RD r3 returns 21.
- Back-pressure: res_ready=0 for 5 cycles with 3 commands offered -> exactly 2 accepted, cmd_ready low thereafter, res_data frozen. Release -> results emerge in order with none lost or duplicated.
- Carry chain (WIDTH=32): LDI r1=0xFFFFFFFF, LDI r2=1, ADD r3=r1+r2, then ADDC r4=r0+r0 -> r3=0 with carry 1; r4=1 with carry 0.
- Saturation: cmd_sat=1 ADD 0xFFFFFFF0+0x20 -> 0xFFFFFFFF, res_carry=1. SUB 3-5 -> 0, res_carry=1.
- Zero register plus mid-op reset: LDI r0=9 then RD r0 -> 0. Assert reset with the pipe full -> res_valid=0 immediately; after release RD r1 -> 0.
